ppu_vram_arbiter: RTL and testbench

Shares the PPU's single VRAM port between three requesters: the background fetch sequencer, the sprite fetch sequencer, and the CPU PPUDATA ($2007) access path. It sits between the fetch FSMs and CPU register file on one side and the synchronous VRAM on the other. Each access is issued as a fixed two-cycle bus transaction, and read data is returned only to the owning requester. Priority is BG > SPR > CPU, with an anti-starvation promotion for the CPU so PPUDATA traffic always completes.

---
 rtl/ppu_pkg.sv | 24 ++
 rtl/ppu_arb_prio.sv | 35 +++
 rtl/ppu_vram_arbiter.sv | 152 +++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared encodings for the PPU VRAM arbiter: bus states, requester owner codes
// and the owner-to-one-hot helper used by the arbiter and its priority select.
package ppu_pkg;

  localparam int PPU_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } bus_state_t;

  typedef enum logic [1:0] {
    OWN_BG  = 2'd0,
    OWN_SPR = 2'd1,
    OWN_CPU = 2'd2
  } owner_t;

  // One-hot bit position equals the owner code: bit0 BG, bit1 SPR, bit2 CPU.
  function automatic logic [2:0] owner_onehot(input owner_t owner);
    return 3'b001 << owner;
  endfunction

endpackage

// File: rtl/ppu_arb_prio.sv
// Combinational winner select for the VRAM bus: BG > SPR > CPU, with the CPU
// lifted above SPR (never above BG) once it has been starved.
module ppu_arb_prio
  import ppu_pkg::*;
(
  input  logic       i_bg_elig,
  input  logic       i_spr_elig,
  input  logic       i_cpu_elig,
  input  logic       i_cpu_starved,
  output logic       o_any,
  output logic [2:0] o_onehot,
  output owner_t     o_owner
);

  always_comb begin
    o_onehot = 3'b000;
    o_owner  = OWN_BG;
    if (i_bg_elig) begin
      o_onehot = owner_onehot(OWN_BG);
      o_owner  = OWN_BG;
    end else if (i_cpu_elig && i_cpu_starved) begin
      o_onehot = owner_onehot(OWN_CPU);
      o_owner  = OWN_CPU;
    end else if (i_spr_elig) begin
      o_onehot = owner_onehot(OWN_SPR);
      o_owner  = OWN_SPR;
    end else if (i_cpu_elig) begin
      o_onehot = owner_onehot(OWN_CPU);
      o_owner  = OWN_CPU;
    end
  end

  assign o_any = |o_onehot;

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Shares the single synchronous VRAM port between BG fetch, sprite fetch and
// CPU PPUDATA access using fixed two-cycle ISSUE/CAPTURE bus transactions.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int ADDR_W       = PPU_ADDR_W,
  parameter int DATA_W       = 8,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_render_en,
  input  logic              i_bg_req,
  input  logic              i_spr_req,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_bg_addr,
  input  logic [ADDR_W-1:0] i_spr_addr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_we,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_bg_gnt,
  output logic              o_spr_gnt,
  output logic              o_cpu_gnt,
  output logic              o_bg_rvalid,
  output logic              o_spr_rvalid,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_vram_ce,
  output logic              o_vram_we,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [DATA_W-1:0] o_vram_wdata,
  input  logic [DATA_W-1:0] i_vram_rdata
);

  localparam int              WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

  bus_state_t        r_state, w_state_next;
  owner_t            r_owner, w_owner_next;
  logic              r_owner_we, w_owner_we_next;
  logic [2:0]        r_gnt, w_gnt_next;
  logic [2:0]        r_rvalid, w_rvalid_next;
  logic [DATA_W-1:0] r_rdata, w_rdata_next;
  logic              r_vram_ce, w_vram_ce_next;
  logic              r_vram_we, w_vram_we_next;
  logic [ADDR_W-1:0] r_vram_addr, w_vram_addr_next;
  logic [DATA_W-1:0] r_vram_wdata, w_vram_wdata_next;
  logic [WAIT_W-1:0] r_cpu_wait;

  logic              w_cpu_starved;
  logic              w_any;
  logic [2:0]        w_win_onehot;
  owner_t            w_win_owner;

  assign w_cpu_starved = (r_cpu_wait >= MAX_WAIT);

  ppu_arb_prio u_prio (
    .i_bg_elig     (i_bg_req && i_render_en),
    .i_spr_elig    (i_spr_req && i_render_en),
    .i_cpu_elig    (i_cpu_req),
    .i_cpu_starved (w_cpu_starved),
    .o_any         (w_any),
    .o_onehot      (w_win_onehot),
    .o_owner       (w_win_owner)
  );

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_owner_we_next   = r_owner_we;
    w_gnt_next        = 3'b000;
    w_rvalid_next     = 3'b000;
    w_rdata_next      = r_rdata;
    w_vram_ce_next    = 1'b0;
    w_vram_we_next    = 1'b0;
    w_vram_addr_next  = r_vram_addr;
    w_vram_wdata_next = r_vram_wdata;
    case (r_state)
      IDLE, CAPTURE: begin
        // RAM data for the access issued last cycle is valid now.
        if (r_state == CAPTURE && !r_owner_we) begin
          w_rvalid_next = owner_onehot(r_owner);
          w_rdata_next  = i_vram_rdata;
        end
        if (w_any) begin
          w_state_next    = ISSUE;
          w_owner_next    = w_win_owner;
          w_owner_we_next = (w_win_owner == OWN_CPU) && i_cpu_we;
          w_gnt_next      = w_win_onehot;
          w_vram_ce_next  = 1'b1;
          w_vram_we_next  = (w_win_owner == OWN_CPU) && i_cpu_we;
          case (w_win_owner)
            OWN_SPR: w_vram_addr_next = i_spr_addr;
            OWN_CPU: w_vram_addr_next = i_cpu_addr;
            default: w_vram_addr_next = i_bg_addr;
          endcase
          w_vram_wdata_next = (w_win_owner == OWN_CPU) ? i_cpu_wdata : '0;
        end else begin
          w_state_next = IDLE;
        end
      end
      ISSUE:   w_state_next = CAPTURE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWN_BG;
      r_owner_we   <= 1'b0;
      r_gnt        <= 3'b000;
      r_rvalid     <= 3'b000;
      r_rdata      <= '0;
      r_vram_ce    <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
      r_cpu_wait   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_owner_we   <= w_owner_we_next;
      r_gnt        <= w_gnt_next;
      r_rvalid     <= w_rvalid_next;
      r_rdata      <= w_rdata_next;
      r_vram_ce    <= w_vram_ce_next;
      r_vram_we    <= w_vram_we_next;
      r_vram_addr  <= w_vram_addr_next;
      r_vram_wdata <= w_vram_wdata_next;
      // Wait counts cycles the CPU has been kept off the bus; saturates.
      if (!i_cpu_req || r_gnt[2]) begin
        r_cpu_wait <= '0;
      end else if (!w_cpu_starved) begin
        r_cpu_wait <= r_cpu_wait + 1'b1;
      end
    end
  end

  assign o_bg_gnt     = r_gnt[0];
  assign o_spr_gnt    = r_gnt[1];
  assign o_cpu_gnt    = r_gnt[2];
  assign o_bg_rvalid  = r_rvalid[0];
  assign o_spr_rvalid = r_rvalid[1];
  assign o_cpu_rvalid = r_rvalid[2];
  assign o_rdata      = r_rdata;
  assign o_vram_ce    = r_vram_ce;
  assign o_vram_we    = r_vram_we;
  assign o_vram_addr  = r_vram_addr;
  assign o_vram_wdata = r_vram_wdata;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: single-access vector table, multi-cycle corner
// sequences, and a grant-to-rvalid scoreboard run every cycle.
module tb_ppu_vram_arbiter;
  import ppu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        render_en = 1'b0;
  logic        bg_req = 1'b0, spr_req = 1'b0, cpu_req = 1'b0;
  logic [13:0] bg_addr = '0, spr_addr = '0, cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic        o_bg_gnt, o_spr_gnt, o_cpu_gnt;
  logic        o_bg_rvalid, o_spr_rvalid, o_cpu_rvalid;
  logic [7:0]  o_rdata;
  logic        o_vram_ce, o_vram_we;
  logic [13:0] o_vram_addr;
  logic [7:0]  o_vram_wdata;
  logic [7:0]  i_vram_rdata = '0;

  always #20 clk = ~clk;

  ppu_vram_arbiter #(.ADDR_W(14), .DATA_W(8), .CPU_MAX_WAIT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_render_en(render_en),
    .i_bg_req(bg_req), .i_spr_req(spr_req), .i_cpu_req(cpu_req),
    .i_bg_addr(bg_addr), .i_spr_addr(spr_addr), .i_cpu_addr(cpu_addr),
    .i_cpu_we(cpu_we), .i_cpu_wdata(cpu_wdata),
    .o_bg_gnt(o_bg_gnt), .o_spr_gnt(o_spr_gnt), .o_cpu_gnt(o_cpu_gnt),
    .o_bg_rvalid(o_bg_rvalid), .o_spr_rvalid(o_spr_rvalid), .o_cpu_rvalid(o_cpu_rvalid),
    .o_rdata(o_rdata), .o_vram_ce(o_vram_ce), .o_vram_we(o_vram_we),
    .o_vram_addr(o_vram_addr), .o_vram_wdata(o_vram_wdata), .i_vram_rdata(i_vram_rdata)
  );

  typedef struct packed {
    owner_t     owner;
    logic       render;
    logic [13:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic       exp_gnt;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    owner_t     owner;
    logic [7:0] data;
    int         due;
  } sb_t;

  logic [7:0] vram    [0:16383];
  logic [7:0] exp_mem [0:16383];
  sb_t        sb_q[$];
  vec_t       vecs[8];
  int         gnt_cnt[3], gnt_cyc[3], rv_cnt[3];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic get_gnt(input owner_t o);
    case (o)
      OWN_BG:  return o_bg_gnt;
      OWN_SPR: return o_spr_gnt;
      default: return o_cpu_gnt;
    endcase
  endfunction

  function automatic logic get_rvalid(input owner_t o);
    case (o)
      OWN_BG:  return o_bg_rvalid;
      OWN_SPR: return o_spr_rvalid;
      default: return o_cpu_rvalid;
    endcase
  endfunction

  // Per-cycle scoreboard: a grant pushes the expected read, an rvalid pops it.
  task automatic monitor();
    logic [2:0]  gv, rv;
    owner_t      own;
    logic [13:0] ea;
    logic        ewe;
    sb_t         e;
    if (!rst_n) begin
      sb_q.delete();
      return;
    end
    gv = {o_cpu_gnt, o_spr_gnt, o_bg_gnt};
    rv = {o_cpu_rvalid, o_spr_rvalid, o_bg_rvalid};
    if (gv != 3'b000) begin
      chk("one_gnt", 32'($countones(gv)), 32'd1);
      own = gv[0] ? OWN_BG : (gv[1] ? OWN_SPR : OWN_CPU);
      gnt_cyc[int'(own)] = cyc;
      gnt_cnt[int'(own)]++;
      ea  = (own == OWN_BG) ? bg_addr : ((own == OWN_SPR) ? spr_addr : cpu_addr);
      ewe = (own == OWN_CPU) && cpu_we;
      chk("gnt_ce", 32'(o_vram_ce), 32'd1);
      chk("gnt_addr", 32'(o_vram_addr), 32'(ea));
      chk("gnt_we", 32'(o_vram_we), 32'(ewe));
      if (ewe) begin
        chk("gnt_wdata", 32'(o_vram_wdata), 32'(cpu_wdata));
        exp_mem[ea] = cpu_wdata;
      end else begin
        sb_q.push_back('{owner: own, data: exp_mem[ea], due: cyc + 2});
      end
    end
    for (int b = 0; b < 3; b++) if (rv[b]) rv_cnt[b]++;
    if (rv != 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(rv), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rvalid_owner", 32'(rv), 32'(owner_onehot(e.owner)));
        chk("rvalid_data", 32'(o_rdata), 32'(e.data));
        chk("rvalid_cycle", cyc, e.due);
      end
    end
  endtask

  // One clock: scoreboard at negedge, VRAM model at posedge, then #1 for stimulus.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    if (o_vram_ce) begin
      if (o_vram_we) vram[o_vram_addr] = o_vram_wdata;
      else i_vram_rdata <= vram[o_vram_addr];
    end
    cyc++;
    #1;
  endtask

  task automatic drive_req(input owner_t o, input logic [13:0] a, input logic we, input logic [7:0] wd);
    case (o)
      OWN_BG:  begin bg_req = 1'b1; bg_addr = a; end
      OWN_SPR: begin spr_req = 1'b1; spr_addr = a; end
      default: begin cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd; end
    endcase
  endtask

  task automatic quiet();
    bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int t, base, rbase;
    logic [2:0] pg;
    logic bg_back, spr_back, stop;
    vec_t v;

    for (int a = 0; a < 16384; a++) begin
      vram[a]    = pat(14'(a));
      exp_mem[a] = pat(14'(a));
    end
    vram[14'h2005]    = 8'hA7;
    exp_mem[14'h2005] = 8'hA7;
    for (int i = 0; i < 3; i++) begin gnt_cnt[i] = 0; gnt_cyc[i] = -1; rv_cnt[i] = 0; end

    vecs[0] = '{OWN_CPU, 1'b1, 14'h2005, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA7};
    vecs[1] = '{OWN_CPU, 1'b1, 14'h23C0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{OWN_CPU, 1'b1, 14'h23C0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55};
    vecs[3] = '{OWN_BG,  1'b1, 14'h0123, 1'b0, 8'h00, 1'b1, 1'b1, pat(14'h0123)};
    vecs[4] = '{OWN_SPR, 1'b1, 14'h1FF0, 1'b0, 8'h00, 1'b1, 1'b1, pat(14'h1FF0)};
    vecs[5] = '{OWN_BG,  1'b0, 14'h0456, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{OWN_SPR, 1'b0, 14'h0789, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{OWN_CPU, 1'b0, 14'h3F00, 1'b0, 8'h00, 1'b1, 1'b1, pat(14'h3F00)};

    repeat (3) step();
    chk("reset_strobes", 32'({o_bg_gnt, o_spr_gnt, o_cpu_gnt, o_bg_rvalid, o_spr_rvalid,
                              o_cpu_rvalid, o_vram_ce, o_vram_we}), 32'd0);
    chk("reset_addr", 32'(o_vram_addr), 32'd0);
    chk("reset_data", 32'({o_vram_wdata, o_rdata}), 32'd0);
    rst_n = 1'b1;
    quiet();

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      base = gnt_cnt[int'(v.owner)];
      step(); render_en = v.render; drive_req(v.owner, v.addr, v.we, v.wdata);
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(get_gnt(v.owner)), 32'(v.exp_gnt));
      step();
      if (v.exp_gnt) begin bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; end
      step();
      chk($sformatf("vec%0d_rvalid", i), 32'(get_rvalid(v.owner)), 32'(v.exp_rvalid));
      if (v.exp_rvalid) chk($sformatf("vec%0d_rdata", i), 32'(o_rdata), 32'(v.exp_rdata));
      repeat (2) step();
      quiet();
      chk($sformatf("vec%0d_gnt_cnt", i), gnt_cnt[int'(v.owner)] - base, 32'(v.exp_gnt));
      $display("vec %0d owner=%0d addr=%h we=%0d done", i, v.owner, v.addr, v.we);
    end

    // Simultaneous BG/SPR/CPU: grants at T+1, T+3, T+5.
    step(); render_en = 1'b1;
    drive_req(OWN_BG, 14'h0040, 1'b0, 8'h00);
    drive_req(OWN_SPR, 14'h1010, 1'b0, 8'h00);
    drive_req(OWN_CPU, 14'h2005, 1'b0, 8'h00);
    t = cyc;
    for (int k = 0; k < 12; k++) begin
      pg = {o_cpu_gnt, o_spr_gnt, o_bg_gnt};
      step();
      if (pg[0]) bg_req = 1'b0;
      if (pg[1]) spr_req = 1'b0;
      if (pg[2]) cpu_req = 1'b0;
    end
    chk("sim_bg_cyc", gnt_cyc[0], t + 1);
    chk("sim_spr_cyc", gnt_cyc[1], t + 3);
    chk("sim_cpu_cyc", gnt_cyc[2], t + 5);
    $display("simultaneous: gnt bg=%0d spr=%0d cpu=%0d (T=%0d)", gnt_cyc[0], gnt_cyc[1], gnt_cyc[2], t);
    quiet();

    // BG/SPR alternation starves a CPU write until the wait counter saturates.
    step(); render_en = 1'b1;
    drive_req(OWN_BG, 14'h0200, 1'b0, 8'h00);
    drive_req(OWN_SPR, 14'h1000, 1'b0, 8'h00);
    drive_req(OWN_CPU, 14'h23C0, 1'b1, 8'h55);
    t = cyc; base = gnt_cnt[2]; rbase = rv_cnt[2];
    bg_back = 1'b0; spr_back = 1'b0; stop = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pg = {o_cpu_gnt, o_spr_gnt, o_bg_gnt};
      step();
      if (pg[0]) begin bg_req = 1'b0; bg_back = 1'b1; end
      else if (bg_back) begin bg_req = !stop; bg_back = 1'b0; end
      if (pg[1]) begin spr_req = 1'b0; spr_back = 1'b1; end
      else if (spr_back) begin spr_req = !stop; spr_back = 1'b0; end
      if (pg[2]) begin cpu_req = 1'b0; cpu_we = 1'b0; stop = 1'b1; end
    end
    chk("starve_cpu_cyc", gnt_cyc[2], t + 19);
    chk("starve_cpu_cnt", gnt_cnt[2] - base, 32'd1);
    chk("starve_no_rvalid", rv_cnt[2] - rbase, 32'd0);
    $display("starvation: cpu gnt at %0d (T=%0d)", gnt_cyc[2], t);
    quiet();

    // render_en=0: BG/SPR ignored, CPU read granted immediately.
    step(); render_en = 1'b0;
    drive_req(OWN_BG, 14'h0111, 1'b0, 8'h00);
    drive_req(OWN_SPR, 14'h0222, 1'b0, 8'h00);
    drive_req(OWN_CPU, 14'h0333, 1'b0, 8'h00);
    t = cyc; base = gnt_cnt[0] + gnt_cnt[1];
    step();
    chk("render0_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
    step(); cpu_req = 1'b0;
    repeat (6) step();
    chk("render0_cpu_cyc", gnt_cyc[2], t + 1);
    chk("render0_bgspr_cnt", gnt_cnt[0] + gnt_cnt[1], base);
    $display("render_en=0: cpu gnt at %0d (T=%0d)", gnt_cyc[2], t);
    quiet();

    // render_en falls after BG is latched: access completes, later BG ignored.
    step(); render_en = 1'b1; drive_req(OWN_BG, 14'h0300, 1'b0, 8'h00);
    base = gnt_cnt[0];
    step();
    chk("render_fall_gnt", 32'(o_bg_gnt), 32'd1);
    render_en = 1'b0;
    repeat (2) step();
    chk("render_fall_rvalid", 32'(o_bg_rvalid), 32'd1);
    repeat (4) step();
    chk("render_fall_cnt", gnt_cnt[0] - base, 32'd1);
    $display("render_en fall: bg grants=%0d", gnt_cnt[0] - base);
    quiet();

    // Reset during CAPTURE of a BG read.
    step(); render_en = 1'b1; drive_req(OWN_BG, 14'h0345, 1'b0, 8'h00);
    step();
    step(); bg_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", 32'({o_bg_gnt, o_spr_gnt, o_cpu_gnt, o_bg_rvalid, o_spr_rvalid,
                            o_cpu_rvalid, o_vram_ce, o_vram_we}), 32'd0);
    chk("rst_addr", 32'(o_vram_addr), 32'd0);
    chk("rst_data", 32'({o_vram_wdata, o_rdata}), 32'd0);
    rbase = rv_cnt[0];
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst_no_bg_rvalid", rv_cnt[0] - rbase, 32'd0);
    step(); drive_req(OWN_CPU, 14'h0111, 1'b0, 8'h00);
    step();
    chk("post_rst_gnt", 32'(o_cpu_gnt), 32'd1);
    step(); cpu_req = 1'b0;
    step();
    chk("post_rst_rvalid", 32'(o_cpu_rvalid), 32'd1);
    chk("post_rst_rdata", 32'(o_rdata), 32'(pat(14'h0111)));
    $display("reset in CAPTURE: post-reset read rdata=%h", o_rdata);
    quiet();

    // Requester holds req one cycle past gnt: second access 2 cycles later.
    step(); drive_req(OWN_CPU, 14'h2005, 1'b0, 8'h00);
    base = gnt_cnt[2];
    step();
    step();
    step(); cpu_req = 1'b0;
    chk("hold_second_gnt", 32'(o_cpu_gnt), 32'd1);
    repeat (4) step();
    chk("hold_gnt_cnt", gnt_cnt[2] - base, 32'd2);
    $display("held req: cpu grants=%0d", gnt_cnt[2] - base);
    quiet();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
